// File: rtl/text_render.sv
// PC-8001 80x25 text renderer: VRAM/CG fetch, 8-pixel serialiser,
// blinking block cursor, and sync delay matched to the pixel path.
module text_render #(
  parameter int ROW_BYTES = 120,
  parameter int V_TOP     = 40,
  parameter int BLINK_BIT = 4
) (
  input  logic        I_CLK,
  input  logic        I_RST_N,
  input  logic [9:0]  I_H_CNT,
  input  logic [9:0]  I_V_CNT,
  input  logic        I_HS,
  input  logic        I_VS,
  output logic [11:0] O_VRAM_ADDR,
  input  logic [7:0]  I_VRAM_DATA,
  output logic [10:0] O_CG_ADDR,
  input  logic [7:0]  I_CG_DATA,
  input  logic [2:0]  I_COLOR,
  input  logic        I_CSR_EN,
  input  logic [6:0]  I_CSR_X,
  input  logic [4:0]  I_CSR_Y,
  output logic [3:0]  O_R,
  output logic [3:0]  O_G,
  output logic [3:0]  O_B,
  output logic        O_HS,
  output logic        O_VS
);

  localparam logic [9:0]  LP_VTOP = 10'(V_TOP);
  localparam logic [9:0]  LP_VEND = 10'(V_TOP + 400);
  localparam logic [11:0] LP_RB   = 12'(ROW_BYTES);

  logic        w_hact;
  logic        w_vact;
  logic        w_act;
  logic        w_fetch;
  logic [7:0]  w_yh;
  logic [4:0]  w_row;
  logic [2:0]  w_line;
  logic [6:0]  w_col;
  logic [11:0] w_addr;
  logic        w_cur;
  logic        w_on;

  logic [3:0]  r_vld;
  logic [2:0]  r_line;
  logic        r_cur;
  logic [2:0]  r_col;
  logic [7:0]  r_hold;
  logic [2:0]  r_hcol;
  logic [7:0]  r_sh;
  logic [2:0]  r_scol;
  logic [7:0]  r_act;
  logic [8:0]  r_hs;
  logic [8:0]  r_vs;
  logic [7:0]  r_frm;

  assign w_hact  = I_H_CNT < 10'd640;
  assign w_vact  = (I_V_CNT >= LP_VTOP)
                && (I_V_CNT < LP_VEND);
  assign w_act   = w_hact & w_vact;
  assign w_fetch = w_act & (I_H_CNT[2:0] == 3'd0);

  // Halved y: each font line is shown on two scanlines.
  assign w_yh   = 8'((I_V_CNT - LP_VTOP) >> 1);
  assign w_row  = w_yh[7:3];
  assign w_line = w_yh[2:0];
  assign w_col  = I_H_CNT[9:3];
  assign w_addr = {7'd0, w_row} * LP_RB
                + {5'd0, w_col};

  assign w_cur = I_CSR_EN
               & r_frm[BLINK_BIT]
               & (w_row == I_CSR_Y)
               & (w_col == I_CSR_X);

  assign w_on = r_act[7] & r_sh[7];

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_vld       <= '0;
      r_line      <= '0;
      r_cur       <= 1'b0;
      r_col       <= '0;
      O_VRAM_ADDR <= '0;
      O_CG_ADDR   <= '0;
      r_hold      <= '0;
      r_hcol      <= '0;
    end else begin
      r_vld <= {r_vld[2:0], w_fetch};
      if (w_fetch) begin
        O_VRAM_ADDR <= w_addr;
        r_line      <= w_line;
        r_cur       <= w_cur;
        r_col       <= I_COLOR;
      end
      if (r_vld[1]) begin
        O_CG_ADDR <= {I_VRAM_DATA, r_line};
      end
      if (r_vld[3]) begin
        r_hold <= I_CG_DATA ^ {8{r_cur}};
        r_hcol <= r_col;
      end
    end
  end

  // Load on phase 7 so the MSB is shown at H = 8c+9.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_sh   <= '0;
      r_scol <= '0;
      r_act  <= '0;
      O_R    <= '0;
      O_G    <= '0;
      O_B    <= '0;
    end else begin
      if (I_H_CNT[2:0] == 3'd7) begin
        r_sh   <= r_hold;
        r_scol <= r_hcol;
      end else begin
        r_sh <= {r_sh[6:0], 1'b0};
      end
      r_act <= {r_act[6:0], w_act};
      O_G   <= {4{w_on & r_scol[2]}};
      O_R   <= {4{w_on & r_scol[1]}};
      O_B   <= {4{w_on & r_scol[0]}};
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_hs  <= '1;
      r_vs  <= '1;
      r_frm <= '0;
    end else begin
      r_hs <= {r_hs[7:0], I_HS};
      r_vs <= {r_vs[7:0], I_VS};
      if (I_H_CNT == 10'd0 && I_V_CNT == 10'd0) begin
        r_frm <= r_frm + 8'd1;
      end
    end
  end

  assign O_HS = r_hs[8];
  assign O_VS = r_vs[8];

endmodule

// File: doc/text_render.md
# text_render

Text-mode pixel pipeline for the PC-8001 VGA path. It sits directly downstream of the horizontal/vertical timing generator, taking its 25 MHz H/V counters and HS/VS. From these it fetches character codes from VRAM and patterns from the character-generator ROM, then serialises 8-pixel cells. It drives 4-bit RGB and re-aligned syncs to the DE0 VGA DAC, rendering 80×25 characters (8×8 font, each line doubled) in a 640×400 window centred in 640×480.

## Interface
- ROW_BYTES, 120: VRAM bytes per text row (80 codes + 40 attribute bytes; attributes ignored).
- V_TOP, 40: first active V count; window is V_TOP..V_TOP+399.
- BLINK_BIT, 4: frame-counter bit giving cursor blink phase.
- I_CLK  in  1  25 MHz pixel clock.
- I_RST_N  in  1  asynchronous, active-low reset.
- I_H_CNT  in  10  horizontal count, 0..799, active 0..639.
- I_V_CNT  in  10  vertical count, 0..524.
- I_HS, I_VS  in  1 each  syncs from timing generator, active low.
- O_VRAM_ADDR  out  12  VRAM byte address.
- I_VRAM_DATA  in  8  character code; synchronous RAM, valid the cycle after O_VRAM_ADDR.
- O_CG_ADDR  out  11  {code[7:0], font line[2:0]}.
- I_CG_DATA  in  8  pattern byte, bit 7 = leftmost pixel; valid the cycle after O_CG_ADDR.
- I_COLOR  in  3  foreground {G,R,B}; background is black.
- I_CSR_EN  in  1  cursor enable.
- I_CSR_X  in  7  cursor column, 0..79.
- I_CSR_Y  in  5  cursor row, 0..24.
- O_R, O_G, O_B  out  4 each  pixel colour.
- O_HS, O_VS  out  1 each  syncs delayed to match the pixels.

## Operation
- Active test: Hact = I_H_CNT < 640; Vact = V_TOP ≤ I_V_CNT < V_TOP+400.
- y = I_V_CNT − V_TOP (9 bits), text row = y[8:4], font line = y[3:1].
- Fetch sequence, cycle t where I_H_CNT = 8c (c = 0..79), Hact and Vact true:
  - t+1: O_VRAM_ADDR = row·ROW_BYTES + c, computed with 12-bit arithmetic.
  - t+2: capture I_VRAM_DATA.
  - t+3: O_CG_ADDR = {code, line}.
  - t+4: capture I_CG_DATA into a hold register.
- Shift register: loads the hold byte once per cell on a fixed phase and shifts MSB-first, one bit per clock.
- Cursor: when I_CSR_EN is set, blink phase is 1, row = I_CSR_Y and c = I_CSR_X, the hold byte is inverted (reverse-video block).
- Blink frame counter: 8 bits, incremented when I_H_CNT=0 and I_V_CNT=0, wraps 255→0. Phase = counter[BLINK_BIT].
- Pixel output: bit=1 gives {G,R,B} = I_COLOR, with each set channel driven as 4'hF. Bit=0, or outside the delayed active window, gives 0 on all channels.
- No fetch outside the active window; O_VRAM_ADDR and O_CG_ADDR hold their last values.

## Timing
- Fixed pixel latency of 9 clocks: pixel (x, y) appears on O_R/G/B in the cycle when I_H_CNT = x+9 on the same line.
  - Cell c thus spans H counts 8c+9..8c+16.
  - The last pixel, x=639, appears at I_H_CNT=648.
- O_HS/O_VS: I_HS/I_VS through a 9-stage register pipe, so sync-to-pixel alignment is unchanged from the timing generator.
- The active flag is pipelined by the same 9 stages. Blanking never shows pattern residue from the previous cell or line.
- Row boundary: row/line are sampled at fetch cycle t. Fetch for c=79 completes at H=636, so no cross-line hazard exists.
- Cursor or colour inputs changed mid-line take effect from the next fetched cell. Cells already in the pipe are unaffected.
- Reset (asserted at any time, including mid-line): all outputs asynchronously return to their reset values.
  - O_R/G/B = 0, O_VRAM_ADDR = 0, O_CG_ADDR = 0.
  - O_HS = O_VS = 1; sync pipe filled with 1.
  - Shift/hold registers = 0, frame counter = 0.
  - After release, the first valid pixels appear from the next cell fetch.

## Test plan
- Reset: hold I_RST_N=0 with counters running → RGB=0, O_HS=O_VS=1, addresses 0. Release mid-line → no spurious pixels before the next fetched cell.
- Cell 0: VRAM[0]=0x41, CG[{0x41,0}]=0x81, I_COLOR=3'b111, V=40 → O_VRAM_ADDR=0 at H=1, O_CG_ADDR=0x208 at H=3. RGB=FFF at H=9 and H=16, 000 at H=10..15.
- Last cell: V=424, H=632 → O_VRAM_ADDR=2959 at H=633. No pixel output outside H=9..648.
- Border/sync: V=39 and V=440 → RGB=0 all line. I_HS low at H=656..751 → O_HS low at H=665..760.
- Cursor: I_CSR_EN=1, X=5, Y=0, CG=0x00 at V=40 → cell 5 is all-on (H=49..56) in frames with counter[4]=1, off when counter[4]=0. Toggles every 16 frames.
- Colour: I_COLOR=3'b010, pattern 0xFF → O_R=F, O_G=0, O_B=0 across the whole cell.
